uartrx: RTL and testbench
=========================

# uartrx

UART receiver that deserializes 8N1 frames from an asynchronous serial line into parallel bytes. It is the receive-side counterpart of the `uarttx` transmitter and uses the same bit-timing parameter, so both ends share one baud configuration (217 clocks/bit = 115200 baud at 25 MHz). It sits between the external RX pin and the byte consumer, and presents each received byte with a one-cycle valid strobe.

## Interface
- `CLKS_PER_BIT`, default 217: system clocks per serial bit. Must be ≥ 8. Counter width is `$clog2(CLKS_PER_BIT)`.
- `i_Clock`  input  1  system clock; all logic on the rising edge.
- `i_Reset`  input  1  synchronous, active-high reset.
- `i_RX_Serial`  input  1  asynchronous serial line; idle high.
- `o_RX_DV`  output  1  one-cycle pulse; `o_RX_Byte` is valid in that cycle.
- `o_RX_Byte`  output  8  last correctly framed byte, LSB received first.
- `o_RX_Busy`  output  1  high while a frame is being received or while waiting for line recovery.
- `o_RX_Frame_Err`  output  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- Input synchronizer: 2 flops (`sync1`, `sync2`), both reset to 1. The FSM uses `sync2` only.
- Constant: HALF = (CLKS_PER_BIT-1)/2 (integer division; 108 for 217).
- The clock counter resets to 0 on every state transition and increments by 1 in each other cycle.
- FSM states:
  - IDLE: when `sync2`==0, go to START.
  - START: at count==HALF, sample `sync2`. If 0, go to DATA with bit index 0. If 1, treat as a glitch and go to IDLE with no output pulse.
  - DATA: at count==CLKS_PER_BIT-1, shift `sync2` into shift register bit [index]. If index==7, go to STOP; otherwise increment index. Index wraps 7→0 only through STOP/IDLE.
  - STOP: at count==CLKS_PER_BIT-1, sample `sync2`.
    - If 1: load `o_RX_Byte` from the shift register, pulse `o_RX_DV`, and go to IDLE. The block returns at mid-stop-bit, so it is ready for a start bit that immediately follows.
    - If 0: pulse `o_RX_Frame_Err`, leave `o_RX_Byte` unchanged, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `sync2`==1, then go to IDLE. This covers breaks and stuck-low lines.
- `o_RX_Busy` = (state != IDLE), registered.
- `o_RX_DV` and `o_RX_Frame_Err` are mutually exclusive and never high for more than one consecutive cycle.
- `o_RX_Byte` holds its value until the next good frame.

## Timing
- Reset values: state IDLE, `o_RX_DV`=0, `o_RX_Frame_Err`=0, `o_RX_Busy`=0, `o_RX_Byte`=8'h00, counter 0, index 0, `sync1`=`sync2`=1.
- Reset takes precedence over all other activity. A reset mid-frame aborts the frame with no pulse. If the line is still low after reset, the low level is treated as a start bit; the result is either a frame error or a garbage byte, and this is accepted behaviour.
- Define edge k as the first rising edge at which `sync1` captures the low start bit.
  - `sync2` is low after edge k+1.
  - IDLE→START occurs at edge k+2.
  - Start bit is validated at edge k+2+HALF.
  - Data bit i is sampled at edge k+2+HALF+(i+1)·CLKS_PER_BIT.
  - Stop bit is sampled at edge k+2+HALF+9·CLKS_PER_BIT. `o_RX_DV` or `o_RX_Frame_Err` is high for the cycle after that edge.
  - For 217 clocks/bit, the pulse edge is k+2063.
- Back-to-back frames: the next start edge can arrive ≥ HALF clocks after the stop sample with no lost bytes.
- Glitch rejection: a low pulse shorter than HALF+1 clocks, as seen at `sync2`, produces no output.

## Test plan
- Single frame: 25 MHz clock, CLKS_PER_BIT=217, drive 0xAA in 8N1 → `o_RX_DV` high for exactly 1 cycle at edge k+2063, `o_RX_Byte`=8'hAA, `o_RX_Busy` high from edge k+2 until the DV edge.
- Loopback: `uarttx` `o_TX_Serial` drives `i_RX_Serial`; send 0x3F, 0x00, 0xFF, 0x55 back-to-back → 4 DV pulses with matching bytes in order, and `o_RX_Frame_Err` never asserted.
- Glitch: line low for 50 clocks, then high → no DV, no frame error, `o_RX_Busy` returns to 0 within 112 clocks.
- Framing error: after a good 0x3F, send a frame carrying 0x81 with the stop bit forced low for 3 bit times, then high → one `o_RX_Frame_Err` pulse, no DV, `o_RX_Byte` stays 0x3F, `o_RX_Busy` stays high until the line returns high. A following good 0x12 frame is received correctly.
- Reset mid-frame: assert `i_Reset` for 1 cycle during data bit 3 of a 0xC3 frame, with the line returning high before the next frame → all outputs return to their reset values the next cycle, no pulse is produced for the aborted frame, and the next 0x5A frame is received correctly.
- Baud tolerance: transmit 0xA5 with the bit period at 217±4 clocks → byte received correctly with no frame error.

Source files
------------

// File: rtl/uartrx.sv
`default_nettype none
// ============================================================================
// Module   : uartrx
// Purpose  : 8N1 UART receiver. Deserializes frames arriving on an
//            asynchronous serial line into bytes and presents each good byte
//            with a one-cycle valid strobe. Shares its bit-timing parameter
//            with the matching transmitter.
// Ports    : i_Clock        - system clock, rising edge
//            i_Reset        - synchronous, active-high reset
//            i_RX_Serial    - asynchronous serial input, idle high
//            o_RX_DV        - one-cycle strobe, o_RX_Byte valid in that cycle
//            o_RX_Byte      - last correctly framed byte (LSB first on line)
//            o_RX_Busy      - high while receiving or waiting for line recovery
//            o_RX_Frame_Err - one-cycle strobe when the stop bit is sampled low
// Revision : 1.0 - initial release
// ============================================================================
module uartrx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Busy,
    output logic       o_RX_Frame_Err
);

    localparam int c_CW   = $clog2(CLKS_PER_BIT);
    localparam int c_HALF = (CLKS_PER_BIT - 1) / 2;

    // The counter reads 0 in the cycle after a transition, so the decision
    // edge for "HALF clocks after entering START" is seen at HALF-1. This puts
    // the start check at k+2+HALF and every later sample one full bit apart.
    localparam logic [c_CW-1:0] c_START_LAST = c_CW'(c_HALF - 1);
    localparam logic [c_CW-1:0] c_BIT_LAST   = c_CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [c_CW-1:0] r_count;
    logic [2:0]      r_index;
    logic [7:0]      r_shift;
    logic [7:0]      r_byte;
    logic            r_dv;
    logic            r_ferr;
    logic            r_busy;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_count <= '0;
            r_index <= 3'd0;
            r_shift <= 8'h00;
            r_byte  <= 8'h00;
            r_dv    <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= i_RX_Serial;
            r_sync2 <= r_sync1;
            r_dv    <= 1'b0;
            r_ferr  <= 1'b0;
            r_count <= r_count + c_CW'(1);

            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= S_START;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_count == c_START_LAST) begin
                        r_count <= '0;
                        if (!r_sync2) begin
                            r_state <= S_DATA;
                            r_index <= 3'd0;
                        end else begin
                            // Line went back high before mid-start: glitch.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    if (r_count == c_BIT_LAST) begin
                        r_count          <= '0;
                        r_shift[r_index] <= r_sync2;
                        r_index          <= r_index + 3'd1;
                        if (r_index == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end
                end

                S_STOP: begin
                    if (r_count == c_BIT_LAST) begin
                        r_count <= '0;
                        if (r_sync2) begin
                            // Return at mid-stop so a following start bit
                            // is caught without losing a frame.
                            r_byte  <= r_shift;
                            r_dv    <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_WAIT_HIGH;
                        end
                    end
                end

                S_WAIT_HIGH: begin
                    // Hold off on breaks / stuck-low lines until they recover.
                    if (r_sync2) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_RX_DV        = r_dv;
    assign o_RX_Byte      = r_byte;
    assign o_RX_Busy      = r_busy;
    assign o_RX_Frame_Err = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uartrx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uartrx
// Purpose  : Self-checking bench for uartrx. A behavioural serial driver
//            produces 8N1 frames; expected bytes and pulse times are computed
//            from the frame timing arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uartrx;

    localparam int CPB    = 217;
    localparam int HALF   = (CPB - 1) / 2;
    localparam int DV_LAT = 2 + HALF + 9 * CPB;   // edge k -> pulse edge

    logic       clk;
    logic       rst;
    logic       rx;
    logic       dv;
    logic [7:0] rx_byte;
    logic       busy;
    logic       ferr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Event log filled by the monitor, consumed by the test tasks.
    logic [7:0] dv_q[$];
    int         dv_t[$];
    int         fe_t[$];
    int         busy_rise_t = -1;
    int         busy_fall_t = -1;
    int         dbl_dv      = 0;
    int         dbl_fe      = 0;
    int         both        = 0;
    logic       prev_dv     = 1'b0;
    logic       prev_fe     = 1'b0;
    logic       prev_busy   = 1'b0;

    uartrx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_RX_Serial    (rx),
        .o_RX_DV        (dv),
        .o_RX_Byte      (rx_byte),
        .o_RX_Busy      (busy),
        .o_RX_Frame_Err (ferr)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv === 1'b1) begin
            dv_q.push_back(rx_byte);
            dv_t.push_back(cyc);
        end
        if (ferr === 1'b1) fe_t.push_back(cyc);
        if (dv === 1'b1 && prev_dv) dbl_dv++;
        if (ferr === 1'b1 && prev_fe) dbl_fe++;
        if (dv === 1'b1 && ferr === 1'b1) both++;
        if (busy === 1'b1 && !prev_busy) busy_rise_t = cyc;
        if (busy === 1'b0 && prev_busy) busy_fall_t = cyc;
        prev_dv   = (dv === 1'b1);
        prev_fe   = (ferr === 1'b1);
        prev_busy = (busy === 1'b1);
    end

    initial begin
        #8000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic clear_log();
        dv_q.delete();
        dv_t.delete();
        fe_t.delete();
    endtask

    // Drive one frame. k = edge at which the synchronizer first sees the
    // start bit; h = edge at which it first sees the line high after the stop.
    task automatic send_frame(input logic [7:0] b, input int per,
                              input logic stop_val, input int stop_len,
                              output int k, output int h);
        @(negedge clk);
        rx = 1'b0;
        k  = cyc + 1;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (per) @(negedge clk);
        end
        rx = stop_val;
        repeat (per * stop_len) @(negedge clk);
        rx = 1'b1;
        h  = cyc + 1;
    endtask

    task automatic test_reset();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (dv !== 1'b0)      begin bad++; $display("FAIL reset_dv: got %b expected 0", dv); end
        total++; if (ferr !== 1'b0)    begin bad++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL reset_byte: got %02h expected 00", rx_byte); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int k, h;
        clear_log();
        send_frame(8'hAA, CPB, 1'b1, 1, k, h);
        repeat (20) @(negedge clk);
        total++;
        if (dv_q.size() != 1) begin
            bad++; $display("FAIL single_count: got %0d pulses expected 1", dv_q.size());
        end else begin
            total++; if (dv_q[0] !== 8'hAA) begin bad++; $display("FAIL single_byte: got %02h expected aa", dv_q[0]); end
            total++; if (dv_t[0] != k + DV_LAT) begin bad++; $display("FAIL single_time: got %0d expected %0d", dv_t[0], k + DV_LAT); end
        end
        total++; if (busy_rise_t != k + 2) begin bad++; $display("FAIL single_busy_rise: got %0d expected %0d", busy_rise_t, k + 2); end
        total++; if (busy_fall_t != k + DV_LAT) begin bad++; $display("FAIL single_busy_fall: got %0d expected %0d", busy_fall_t, k + DV_LAT); end
        total++; if (fe_t.size() != 0) begin bad++; $display("FAIL single_ferr: got %0d pulses expected 0", fe_t.size()); end
        total++; if (rx_byte !== 8'hAA) begin bad++; $display("FAIL single_hold: got %02h expected aa", rx_byte); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[$];
        int         exp_t[$];
        logic [7:0] b;
        int k, h;
        clear_log();
        exp_b = '{8'h3F, 8'h00, 8'hFF, 8'h55};
        for (int i = 0; i < 4; i++) exp_b.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < exp_b.size(); i++) begin
            b = exp_b[i];
            send_frame(b, CPB, 1'b1, 1, k, h);
            exp_t.push_back(k + DV_LAT);
        end
        repeat (20) @(negedge clk);
        total++;
        if (dv_q.size() != exp_b.size()) begin
            bad++; $display("FAIL b2b_count: got %0d pulses expected %0d", dv_q.size(), exp_b.size());
        end else begin
            for (int i = 0; i < exp_b.size(); i++) begin
                total++; if (dv_q[i] !== exp_b[i]) begin bad++; $display("FAIL b2b_byte[%0d]: got %02h expected %02h", i, dv_q[i], exp_b[i]); end
                total++; if (dv_t[i] != exp_t[i]) begin bad++; $display("FAIL b2b_time[%0d]: got %0d expected %0d", i, dv_t[i], exp_t[i]); end
            end
        end
        total++; if (fe_t.size() != 0) begin bad++; $display("FAIL b2b_ferr: got %0d pulses expected 0", fe_t.size()); end
    endtask

    task automatic test_glitch();
        int lens[3];
        int k;
        lens[0] = 50;
        lens[1] = $urandom_range(1, HALF);
        lens[2] = HALF;
        for (int i = 0; i < 3; i++) begin
            clear_log();
            busy_fall_t = -1;
            @(negedge clk);
            rx = 1'b0;
            k  = cyc + 1;
            repeat (lens[i]) @(negedge clk);
            rx = 1'b1;
            repeat (150) @(negedge clk);
            total++; if (dv_q.size() != 0) begin bad++; $display("FAIL glitch_dv len=%0d: got %0d pulses expected 0", lens[i], dv_q.size()); end
            total++; if (fe_t.size() != 0) begin bad++; $display("FAIL glitch_ferr len=%0d: got %0d pulses expected 0", lens[i], fe_t.size()); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy len=%0d: got %b expected 0", lens[i], busy); end
            total++;
            if (busy_fall_t < k || busy_fall_t - k > 112) begin
                bad++; $display("FAIL glitch_recover len=%0d: busy fell %0d clocks after start, required 0..112", lens[i], busy_fall_t - k);
            end
        end
    endtask

    task automatic test_frame_err();
        int k, h;
        clear_log();
        send_frame(8'h3F, CPB, 1'b1, 1, k, h);
        repeat (20) @(negedge clk);
        total++; if (dv_q.size() != 1 || dv_q[0] !== 8'h3F) begin bad++; $display("FAIL ferr_pre: got %0d pulses / byte %02h expected 1 / 3f", dv_q.size(), rx_byte); end
        clear_log();
        send_frame(8'h81, CPB, 1'b0, 3, k, h);
        repeat (20) @(negedge clk);
        total++; if (fe_t.size() != 1) begin bad++; $display("FAIL ferr_count: got %0d pulses expected 1", fe_t.size()); end
        else begin
            total++; if (fe_t[0] != k + DV_LAT) begin bad++; $display("FAIL ferr_time: got %0d expected %0d", fe_t[0], k + DV_LAT); end
        end
        total++; if (dv_q.size() != 0) begin bad++; $display("FAIL ferr_dv: got %0d pulses expected 0", dv_q.size()); end
        total++; if (rx_byte !== 8'h3F) begin bad++; $display("FAIL ferr_hold: got %02h expected 3f", rx_byte); end
        total++; if (busy_fall_t != h + 2) begin bad++; $display("FAIL ferr_busy_fall: got %0d expected %0d", busy_fall_t, h + 2); end
        clear_log();
        send_frame(8'h12, CPB, 1'b1, 1, k, h);
        repeat (20) @(negedge clk);
        total++; if (dv_q.size() != 1 || dv_q[0] !== 8'h12) begin bad++; $display("FAIL ferr_post: got %0d pulses / byte %02h expected 1 / 12", dv_q.size(), rx_byte); end
        total++; if (fe_t.size() != 0) begin bad++; $display("FAIL ferr_post_ferr: got %0d pulses expected 0", fe_t.size()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int k, h, hits;
        b = 8'hC3;
        clear_log();
        @(negedge clk);
        rx = 1'b0;
        k  = cyc + 1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == 3) begin
                repeat (HALF) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                total++; if (dv !== 1'b0)      begin bad++; $display("FAIL midrst_dv: got %b expected 0", dv); end
                total++; if (ferr !== 1'b0)    begin bad++; $display("FAIL midrst_ferr: got %b expected 0", ferr); end
                total++; if (busy !== 1'b0)    begin bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
                total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL midrst_byte: got %02h expected 00", rx_byte); end
                rst = 1'b0;
                repeat (CPB - HALF - 1) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        rx = 1'b1;
        repeat (2600) @(negedge clk);
        hits = 0;
        foreach (dv_t[i]) if (dv_t[i] == k + DV_LAT) hits++;
        foreach (fe_t[i]) if (fe_t[i] == k + DV_LAT) hits++;
        total++; if (hits != 0) begin bad++; $display("FAIL midrst_abort: got %0d pulses at aborted frame end expected 0", hits); end
        clear_log();
        send_frame(8'h5A, CPB, 1'b1, 1, k, h);
        repeat (20) @(negedge clk);
        total++; if (dv_q.size() != 1 || dv_q[0] !== 8'h5A) begin bad++; $display("FAIL midrst_next: got %0d pulses / byte %02h expected 1 / 5a", dv_q.size(), rx_byte); end
    endtask

    task automatic test_baud_tol();
        int pers[3];
        logic [7:0] bs[3];
        int k, h;
        pers[0] = CPB - 4;  bs[0] = 8'hA5;
        pers[1] = CPB + 4;  bs[1] = 8'hA5;
        pers[2] = $urandom_range(CPB - 4, CPB + 4);
        bs[2]   = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3; i++) begin
            clear_log();
            send_frame(bs[i], pers[i], 1'b1, 1, k, h);
            repeat (40) @(negedge clk);
            total++; if (dv_q.size() != 1 || dv_q[0] !== bs[i]) begin bad++; $display("FAIL tol_byte per=%0d: got %0d pulses / byte %02h expected 1 / %02h", pers[i], dv_q.size(), rx_byte, bs[i]); end
            total++; if (fe_t.size() != 0) begin bad++; $display("FAIL tol_ferr per=%0d: got %0d pulses expected 0", pers[i], fe_t.size()); end
        end
    endtask

    task automatic test_pulse_rules();
        total++; if (dbl_dv != 0) begin bad++; $display("FAIL rule_dv_width: got %0d long pulses expected 0", dbl_dv); end
        total++; if (dbl_fe != 0) begin bad++; $display("FAIL rule_fe_width: got %0d long pulses expected 0", dbl_fe); end
        total++; if (both != 0)   begin bad++; $display("FAIL rule_exclusive: got %0d overlaps expected 0", both); end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_baud_tol();
        test_pulse_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
